// File: rtl/popcount_accumulator.sv
// Popcount accumulator: sums set bits and word counts per frame,
// saturating, with a one-deep result register behind a valid/ready handshake.
module popcount_accumulator #(
  parameter int DATA_WIDTH  = 8,
  parameter int TOTAL_WIDTH = 16,
  parameter int WORDS_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TOTAL_WIDTH-1:0] out_total,
  output logic [WORDS_WIDTH-1:0] out_words,
  output logic                   out_saturated
);

  localparam int CW  = $clog2(DATA_WIDTH + 1);
  localparam int TW1 = TOTAL_WIDTH + 1;
  localparam int WW1 = WORDS_WIDTH + 1;

  typedef enum logic {ACCUMULATE, HOLD} state_e;

  state_e                 state_q, state_d;
  logic                   first_q, first_d;
  logic [TOTAL_WIDTH-1:0] total_q, total_d;
  logic [WORDS_WIDTH-1:0] words_q, words_d;
  logic                   sat_q, sat_d;
  logic [TOTAL_WIDTH-1:0] out_total_q, out_total_d;
  logic [WORDS_WIDTH-1:0] out_words_q, out_words_d;
  logic                   out_sat_q, out_sat_d;

  logic [CW-1:0]          cnt;
  logic [TOTAL_WIDTH-1:0] base_t, new_t;
  logic [WORDS_WIDTH-1:0] base_w, new_w;
  logic                   base_s, new_s;
  logic [TW1-1:0]         sum_t;
  logic [WW1-1:0]         sum_w;
  logic                   in_xfer, out_xfer;

  assign out_valid     = (state_q == HOLD);
  assign in_ready      = (state_q == ACCUMULATE) || out_ready;
  assign in_xfer       = in_valid && in_ready;
  assign out_xfer      = out_valid && out_ready;
  assign out_total     = out_total_q;
  assign out_words     = out_words_q;
  assign out_saturated = out_sat_q;

  // Number of set bits in the incoming word.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      cnt = cnt + CW'(in_data[i]);
    end
  end

  // Running sums including the incoming word; a frame start restarts from zero.
  always_comb begin
    base_t = first_q ? '0 : total_q;
    base_w = first_q ? '0 : words_q;
    base_s = first_q ? 1'b0 : sat_q;
    sum_t  = {1'b0, base_t} + TW1'(cnt);
    sum_w  = {1'b0, base_w} + WW1'(1);
    new_t  = sum_t[TOTAL_WIDTH] ? '1 : sum_t[TOTAL_WIDTH-1:0];
    new_w  = sum_w[WORDS_WIDTH] ? '1 : sum_w[WORDS_WIDTH-1:0];
    new_s  = base_s | sum_t[TOTAL_WIDTH] | sum_w[WORDS_WIDTH];
  end

  // Next state: consume words, publish on last, release on output transfer.
  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    total_d     = total_q;
    words_d     = words_q;
    sat_d       = sat_q;
    out_total_d = out_total_q;
    out_words_d = out_words_q;
    out_sat_d   = out_sat_q;
    if (out_xfer) begin
      state_d = ACCUMULATE;
    end
    if (in_xfer) begin
      total_d = new_t;
      words_d = new_w;
      sat_d   = new_s;
      first_d = in_last;
      if (in_last) begin
        out_total_d = new_t;
        out_words_d = new_w;
        out_sat_d   = new_s;
        state_d     = HOLD;
      end
    end
  end

  // State registers with synchronous reset taking priority over transfers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ACCUMULATE;
      first_q     <= 1'b1;
      total_q     <= '0;
      words_q     <= '0;
      sat_q       <= 1'b0;
      out_total_q <= '0;
      out_words_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      total_q     <= total_d;
      words_q     <= words_d;
      sat_q       <= sat_d;
      out_total_q <= out_total_d;
      out_words_q <= out_words_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: doc/popcount_accumulator.md
POPCOUNT_ACCUMULATOR -- requirements
Module: popcount_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of each input word.
REQ-002 SHALL have parameter TOTAL_WIDTH, default 16: width of the frame total (must be >= CLOG2(DATA_WIDTH+1)).
REQ-003 SHALL have parameter WORDS_WIDTH, default 8: width of the frame word counter.
REQ-004 SHALL have port clock  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1: input word present.
REQ-007 SHALL have port in_ready  output  1: block can accept an input word.
REQ-008 SHALL have port in_data  input  DATA_WIDTH: word whose high bits are counted.
REQ-009 SHALL have port in_last  input  1: word is the final word of its frame.
REQ-010 SHALL have port out_valid  output  1: frame result present.
REQ-011 SHALL have port out_ready  input  1: consumer accepts the result.
REQ-012 SHALL have port out_total  output  TOTAL_WIDTH: total high bits in the frame, saturating.
REQ-013 SHALL have port out_words  output  WORDS_WIDTH: words in the frame, saturating.
REQ-014 SHALL have port out_saturated  output  1: out_total or out_words clipped at its maximum.

Function
REQ-015 SHALL accept an input word when in_valid and in_ready are both high on a rising edge (input transfer).
REQ-016 SHALL deliver a result when out_valid and out_ready are both high on a rising edge (output transfer).
REQ-017 SHALL implement two states: ACCUMULATE (out_valid=0) and HOLD (out_valid=1).
REQ-018 SHALL drive in_ready = (state==ACCUMULATE) or out_ready; in_ready SHALL NOT depend on in_valid.
REQ-019 SHALL compute per-word count combinationally as the number of 1 bits in in_data (0..DATA_WIDTH).
REQ-020 SHALL, on input transfer of the first word of a frame, load the running total with that word's count and the word counter with 1.
REQ-021 SHALL, on input transfer of a non-first word, add that word's count to the running total and add 1 to the word counter.
REQ-022 SHALL saturate the running total at 2^TOTAL_WIDTH-1 and the word counter at 2^WORDS_WIDTH-1, never wrapping; a sticky per-frame saturated flag SHALL be set when either clips.
REQ-023 SHALL, on input transfer with in_last=1, register the final total, word count and saturated flag (including this word) into out_total/out_words/out_saturated and enter HOLD; out_valid SHALL be high the cycle after the transfer (latency 1).
REQ-024 SHALL hold out_total, out_words, out_saturated stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, on output transfer with no simultaneous input transfer, return to ACCUMULATE with out_valid=0 the next cycle.
REQ-026 SHALL, on simultaneous output transfer and input transfer, treat the input word as the first word of a new frame; if that word also has in_last=1, stay in HOLD with the new single-word result.
REQ-027 SHALL treat the word following an in_last transfer (or the first word after reset) as a frame start.
REQ-028 SHALL, for a single-word frame, report out_words=1 and out_total=count of that word.
REQ-029 SHALL produce out_total=0 for a frame whose words are all zero.
REQ-030 SHALL ignore in_data/in_last when no input transfer occurs.

Reset
REQ-031 SHALL, with reset high at a rising edge, set state ACCUMULATE, out_valid=0, out_total=0, out_words=0, out_saturated=0, running total=0, word counter=0, saturated flag=0, next word = frame start.
REQ-032 SHALL, when reset is asserted mid-frame or in HOLD, discard the partial frame or pending result entirely.
REQ-033 SHALL give reset priority over any transfer in the same cycle.

Verification
REQ-034 Frame 8'hFF, 8'h0F, 8'h01(last), out_ready=1 -> out_total=13, out_words=3, out_saturated=0, out_valid one cycle after last.
REQ-035 Single word 8'hA5 last, out_ready=0 for 5 cycles -> out_valid held, out_total=4, out_words=1 stable, in_ready=0 until out_ready=1.
REQ-036 Back-to-back: result pending, out_ready=1 and new 8'h03(last) same cycle -> next cycle out_total=2, out_words=1, out_valid stays 1.
REQ-037 TOTAL_WIDTH=4, frame 8'hFF, 8'hFF(last) -> out_total=15, out_words=2, out_saturated=1; next frame 8'h01(last) -> out_total=1, out_saturated=0.
REQ-038 Reset asserted after two words of a frame, then 8'h07(last) -> out_total=3, out_words=1.
REQ-039 Random in_valid/out_ready throttling over 1000 frames -> every result matches reference model; no transfer lost or duplicated.
